// File: rtl/store_narrow_unit_pkg.sv
// store_narrow_unit_pkg: size codes, FSM states and response kinds shared by the store/load path
package store_narrow_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] K_DONE  = 2'd0;
  localparam logic [1:0] K_ADES  = 2'd1;
  localparam logic [1:0] K_BERR  = 2'd2;
endpackage

// File: rtl/store_lane_pack.sv
// store_lane_pack: narrows a register value to byte/half/word lanes and checks fit and alignment
module store_lane_pack
  import store_narrow_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  input  logic        chk_signed,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        fits,
  output logic        err
);
  always_comb begin
    be    = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
    fits  = size == SZ_BYTE ? (chk_signed ? (&data[31:7] | ~|data[31:7]) : ~|data[31:8]) :
            size == SZ_HALF ? (chk_signed ? (&data[31:15] | ~|data[31:15]) : ~|data[31:16]) : 1'b1;
    err   = size == 2'b11 | (size == SZ_HALF & off[0]) | (size == SZ_WORD & |off);
  end
endmodule

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: captures a store, issues one lane-packed memory write and reports done/ades/berr
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  input  logic        st_chk_signed,
  output logic        st_done,
  output logic        st_fits,
  output logic        st_ades,
  output logic        st_berr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be
);
  localparam logic            TO_EN   = TIMEOUT != 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT - 1 : 0);
  logic [1:0]      state, kind, sz_q;
  logic [31:0]     a_q, d_q;
  logic            sg_q, idle, resp, fits, err;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [TO_W-1:0] cnt;
  // In IDLE the packer sees the live request so the error decision is made at accept time.
  store_lane_pack u_pack (
    .size       (idle ? st_size : sz_q),
    .off        (idle ? st_addr[1:0] : a_q[1:0]),
    .data       (idle ? st_data : d_q),
    .chk_signed (idle ? st_chk_signed : sg_q),
    .be         (be),
    .wdata      (wdata),
    .fits       (fits),
    .err        (err)
  );
  always_comb begin
    idle      = state == S_IDLE;
    resp      = state == S_RESP;
    st_ready  = idle;
    mem_valid = state == S_WRITE;
    mem_addr  = mem_valid ? {a_q[31:2], 2'b00} : 32'd0;
    mem_wdata = mem_valid ? wdata : 32'd0;
    mem_be    = mem_valid ? be : 4'd0;
    st_done   = resp & kind == K_DONE;
    st_ades   = resp & kind == K_ADES;
    st_berr   = resp & kind == K_BERR;
    st_fits   = resp & fits;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      kind  <= K_DONE;
      a_q   <= '0;
      d_q   <= '0;
      sz_q  <= SZ_BYTE;
      sg_q  <= 1'b0;
      cnt   <= '0;
    end else if (idle) begin
      if (st_valid) begin
        a_q   <= st_addr;
        d_q   <= st_data;
        sz_q  <= st_size;
        sg_q  <= st_chk_signed;
        cnt   <= '0;
        kind  <= K_ADES;
        state <= err ? S_RESP : S_WRITE;
      end
    end else if (mem_valid) begin
      if (mem_ready) begin
        state <= S_RESP;
        kind  <= K_DONE;
      end else if (TO_EN && cnt == TO_LAST) begin
        state <= S_RESP;
        kind  <= K_BERR;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      state <= S_IDLE;
    end
  end
endmodule
